ex_muldiv_stage: RTL and testbench
==================================

EX_MULDIV_STAGE -- requirements
Module: ex_muldiv_stage

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter CNT_W, default $clog2(XLEN)+1: iteration counter width; it is derived and never overridden.
REQ-003 Clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Reset  in  1: asynchronous, active-high reset.
REQ-005 EX_Flush  in  1: synchronous kill of the in-flight or accepting operation.
REQ-006 ID_Valid  in  1: decode presents an operation this cycle.
REQ-007 ID_Op  in  3: operation code: 000 ADD, 001 MUL (low XLEN), 010 MULHU, 011 DIVU, 100 REMU; 101-111 are treated as ADD.
REQ-008 ID_Rs1_data, ID_Rs2_data  in  XLEN each: register operands.
REQ-009 ForwardA, ForwardB  in  2 each: forwarding selects; 10 = EX_Result, 01 = WB_Rd_data, other values = ID data.
REQ-010 WB_Rd_data  in  XLEN: writeback forwarding source.
REQ-011 ID_RegFile_wr_en  in  1, ID_Rd_addr  in  5: destination write enable and address, carried with the operation.
REQ-012 EX_Stall  out  1: decode must hold its inputs while this is high.
REQ-013 EX_Valid  out  1: EX_Result, EX_Rd_addr and EX_RegFile_wr_en are valid this cycle.
REQ-014 EX_Result  out  XLEN, EX_Rd_addr  out  5, EX_RegFile_wr_en  out  1: registered result outputs.

Function
REQ-015 Operand selection: op1/op2 = forwarding mux (REQ-009), sampled only in the accept cycle; later forwarding changes are ignored.
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 IDLE: ID_Valid=1 with ADD -> result registered next edge, EX_Valid=1 for 1 cycle, no stall (latency 1).
REQ-018 IDLE: ID_Valid=1 with MUL/MULHU/DIVU/REMU -> operands, op, Rd and write enable captured; counter=0; go to BUSY; EX_Stall=1 combinationally in the accept cycle.
REQ-019 BUSY: one radix-2 iteration per cycle (shift-add multiply into a 2*XLEN accumulator; restoring divide); counter++; EX_Stall=1.
REQ-020 BUSY with counter==XLEN-1 -> DONE; the result register is loaded on that edge.
REQ-021 DONE: EX_Valid=1 and EX_Stall=0 for exactly 1 cycle; an operation may be accepted in DONE with the same rules as IDLE (back-to-back).
REQ-022 Total multi-cycle latency: accept edge to EX_Valid = XLEN+1 cycles.
REQ-023 MUL returns product[XLEN-1:0]; MULHU returns product[2*XLEN-1:XLEN]; all arithmetic is unsigned and modulo 2^XLEN.
REQ-024 Divide by zero: DIVU returns all ones, REMU returns op1, and both still take the full XLEN+1 latency.
REQ-025 EX_Valid=0 in every cycle not covered by REQ-017/021; EX_Result holds its last value.
REQ-026 EX_Flush=1 (any state) -> next state IDLE, EX_Valid=0 and EX_RegFile_wr_en=0 next cycle, no accept that cycle; flush has priority over completion.
REQ-027 EX_Result is forwarded via ForwardA/B=10 only when EX_Valid=1; correct select timing is the hazard unit's responsibility.

Reset
REQ-028 Reset=1 asynchronously forces: state=IDLE, counter=0, EX_Valid=0, EX_Stall=0, EX_Result=0, EX_Rd_addr=0, EX_RegFile_wr_en=0, accumulators=0.
REQ-029 Reset asserted mid-BUSY discards the operation; after reset release the first accepted operation behaves as from IDLE.

Verification
REQ-030 XLEN=32: ADD 5+7, Rd=3 -> next cycle EX_Valid=1, EX_Result=12, EX_Rd_addr=3, EX_Stall never high.
REQ-031 XLEN=32: MULHU 0xFFFFFFFF*0xFFFFFFFF -> EX_Stall high 33 cycles from accept, then EX_Valid=1, EX_Result=0xFFFFFFFE; MUL on the same operands gives 0x00000001.
REQ-032 XLEN=32: DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU 100/7 -> 2, each at latency 33.
REQ-033 ForwardA=01, WB_Rd_data=9, ID_Rs1_data=1, ADD with op2=1 -> 10; changing WB_Rd_data during BUSY of a MUL leaves the result unaffected.
REQ-034 EX_Flush at BUSY cycle 10, and again in the DONE-bound cycle -> no EX_Valid; the next ADD completes in 1 cycle.
REQ-035 Reset pulse mid-DIVU, and an XLEN=8 rerun of REQ-031 (0xFF*0xFF -> MUL 0x01, MULHU 0xFE, latency 9) -> all outputs 0, then correct operation.

Source files
------------

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage
//   Execute stage with a single-cycle adder and an iterative radix-2
//   multiply/divide unit. ADD completes the cycle after accept. MUL, MULHU,
//   DIVU and REMU hold decode via EX_Stall until the result has been produced.
//
// Parameters
//   XLEN   operand/result width (8, 16, 32 or 64)
//   CNT_W  iteration counter width, derived from XLEN
//
// Ports
//   Clk, Reset                  clock, asynchronous active-high reset
//   EX_Flush                    kill the in-flight or accepting operation
//   ID_Valid, ID_Op             operation request and opcode
//   ID_Rs1_data, ID_Rs2_data    register operands
//   ForwardA, ForwardB          operand forwarding selects
//   WB_Rd_data                  writeback forwarding source
//   ID_RegFile_wr_en, ID_Rd_addr destination carried with the operation
//   EX_Stall                    decode must hold its inputs
//   EX_Valid                    result outputs valid this cycle
//   EX_Result, EX_Rd_addr, EX_RegFile_wr_en  registered result outputs
//
// state | meaning
// IDLE  | waiting for an operation
// BUSY  | one multiply/divide iteration per cycle
// DONE  | multi-cycle result presented; may accept the next operation
module ex_muldiv_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            EX_Flush,
  input  logic            ID_Valid,
  input  logic [2:0]      ID_Op,
  input  logic [XLEN-1:0] ID_Rs1_data,
  input  logic [XLEN-1:0] ID_Rs2_data,
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] WB_Rd_data,
  input  logic            ID_RegFile_wr_en,
  input  logic [4:0]      ID_Rd_addr,
  output logic            EX_Stall,
  output logic            EX_Valid,
  output logic [XLEN-1:0] EX_Result,
  output logic [4:0]      EX_Rd_addr,
  output logic            EX_RegFile_wr_en
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_REMU  = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              wr_out_q, wr_out_d;

  logic [XLEN-1:0]   op1, op2;
  logic              is_multi, can_accept, accept_add, accept_multi;
  logic              is_mul_q, is_hi_q;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_shift, div_diff;
  logic [2*XLEN-1:0] div_step;

  always_comb begin
    case (ForwardA)
      2'b10:   op1 = result_q;
      2'b01:   op1 = WB_Rd_data;
      default: op1 = ID_Rs1_data;
    endcase
    case (ForwardB)
      2'b10:   op2 = result_q;
      2'b01:   op2 = WB_Rd_data;
      default: op2 = ID_Rs2_data;
    endcase
  end

  assign is_multi = (ID_Op == OP_MUL) || (ID_Op == OP_MULHU) ||
                    (ID_Op == OP_DIVU) || (ID_Op == OP_REMU);
  assign can_accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                        ID_Valid && !EX_Flush;
  assign accept_add   = can_accept && !is_multi;
  assign accept_multi = can_accept && is_multi;

  assign is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULHU);
  // MULHU and REMU both take the upper half of the accumulator.
  assign is_hi_q  = (op_q == OP_MULHU) || (op_q == OP_REMU);

  // Shift-add multiply: upper half accumulates, lower half holds the
  // remaining multiplier bits; carry out of the add shifts into the top.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: upper half is the partial remainder, lower half shifts
  // dividend bits out and quotient bits in. A zero divisor always subtracts,
  // which yields an all-ones quotient and a remainder equal to the dividend.
  assign rem_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = rem_shift - {1'b0, opb_q};
  assign div_step  = div_diff[XLEN] ?
                     {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0} :
                     {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  assign EX_Stall = (state_q == S_BUSY) || accept_multi;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    op_d     = op_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    valid_d  = 1'b0;
    wr_out_d = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;
    if (EX_Flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_d = S_IDLE;
          if (accept_add) begin
            result_d = op1 + op2;
            valid_d  = 1'b1;
            wr_out_d = ID_RegFile_wr_en;
            rd_out_d = ID_Rd_addr;
          end else if (accept_multi) begin
            acc_d   = {{XLEN{1'b0}}, op1};
            opb_d   = op2;
            op_d    = ID_Op;
            rd_d    = ID_Rd_addr;
            wr_d    = ID_RegFile_wr_en;
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          acc_d = is_mul_q ? mul_step : div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            valid_d  = 1'b1;
            wr_out_d = wr_q;
            rd_out_d = rd_q;
            result_d = is_hi_q ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      wr_q     <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
      wr_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      wr_out_q <= wr_out_d;
    end
  end

  assign EX_Valid         = valid_q;
  assign EX_Result        = result_q;
  assign EX_Rd_addr       = rd_out_q;
  assign EX_RegFile_wr_en = wr_out_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed bench for ex_muldiv_stage: a 32-bit and an 8-bit instance share
// clock, reset and control; each has its own valid and data lines.
module tb_ex_muldiv_stage;

  localparam logic [2:0] ADD = 3'b000, MUL = 3'b001, MULHU = 3'b010,
                         DIVU = 3'b011, REMU = 3'b100;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  logic flush = 0, v32 = 0, v8 = 0, wr = 0;
  logic [2:0] op = 0;
  logic [1:0] fa = 0, fb = 0;
  logic [4:0] rd = 0;
  logic [31:0] rs1_32 = 0, rs2_32 = 0, wb_32 = 0;
  logic [7:0]  rs1_8 = 0, rs2_8 = 0, wb_8 = 0;

  logic st32, ev32, wro32, st8, ev8, wro8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic [4:0]  rdo32, rdo8;

  int checks = 0;
  int errors = 0;

  ex_muldiv_stage #(.XLEN(32)) dut32 (
    .Clk(Clk), .Reset(Reset), .EX_Flush(flush), .ID_Valid(v32), .ID_Op(op),
    .ID_Rs1_data(rs1_32), .ID_Rs2_data(rs2_32), .ForwardA(fa), .ForwardB(fb),
    .WB_Rd_data(wb_32), .ID_RegFile_wr_en(wr), .ID_Rd_addr(rd),
    .EX_Stall(st32), .EX_Valid(ev32), .EX_Result(res32), .EX_Rd_addr(rdo32),
    .EX_RegFile_wr_en(wro32));

  ex_muldiv_stage #(.XLEN(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .EX_Flush(flush), .ID_Valid(v8), .ID_Op(op),
    .ID_Rs1_data(rs1_8), .ID_Rs2_data(rs2_8), .ForwardA(fa), .ForwardB(fb),
    .WB_Rd_data(wb_8), .ID_RegFile_wr_en(wr), .ID_Rd_addr(rd),
    .EX_Stall(st8), .EX_Valid(ev8), .EX_Result(res8), .EX_Rd_addr(rdo8),
    .EX_RegFile_wr_en(wro8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then count cycles to EX_Valid and stalled cycles.
  // WB data switches to w_late right after the accept edge.
  task automatic run(input bit w8, input logic [2:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] w,
                     input logic [63:0] w_late, input logic [1:0] fa_i,
                     input logic [4:0] rd_i, input logic [63:0] exp,
                     input int exp_lat, input string tag);
    int lat;
    int stalls;
    @(negedge Clk);
    op = o; fa = fa_i; fb = 2'b00; rd = rd_i; wr = 1'b1;
    if (w8) begin
      v8 = 1'b1; rs1_8 = a[7:0]; rs2_8 = b[7:0]; wb_8 = w[7:0];
    end else begin
      v32 = 1'b1; rs1_32 = a[31:0]; rs2_32 = b[31:0]; wb_32 = w[31:0];
    end
    #1;
    stalls = (w8 ? st8 : st32) ? 1 : 0;
    lat = 0;
    while (lat < 200) begin
      @(negedge Clk);
      v8 = 1'b0; v32 = 1'b0;
      wb_8 = w_late[7:0]; wb_32 = w_late[31:0];
      #1;
      lat++;
      if (w8 ? ev8 : ev32) break;
      if (w8 ? st8 : st32) stalls++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " stall cycles"}, 64'(stalls), 64'((exp_lat == 1) ? 0 : exp_lat));
    chk({tag, " result"}, w8 ? {56'b0, res8} : {32'b0, res32}, exp);
    chk({tag, " rd"}, 64'(w8 ? rdo8 : rdo32), 64'(rd_i));
    chk({tag, " wr_en"}, 64'(w8 ? wro8 : wro32), 64'd1);
    @(negedge Clk);
    #1;
    chk({tag, " valid drops"}, 64'(w8 ? ev8 : ev32), 64'd0);
  endtask

  // Start a MUL on the 32-bit unit and flush it in BUSY cycle `at`.
  task automatic flush_run(input int at, input string tag);
    int seen;
    @(negedge Clk);
    op = MUL; fa = 2'b00; fb = 2'b00; rd = 5'd9; wr = 1'b1;
    v32 = 1'b1; rs1_32 = 32'd3; rs2_32 = 32'd4;
    for (int n = 1; n <= at; n++) begin
      @(negedge Clk);
      v32 = 1'b0;
    end
    flush = 1'b1;
    @(negedge Clk);
    flush = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (ev32 || wro32) seen++;
      @(negedge Clk);
    end
    chk({tag, " no valid after flush"}, 64'(seen), 64'd0);
    chk({tag, " stall idle"}, 64'(st32), 64'd0);
  endtask

  initial begin
    #12;
    chk("reset valid", 64'(ev32), 64'd0);
    chk("reset stall", 64'(st32), 64'd0);
    chk("reset result", 64'(res32), 64'd0);
    chk("reset rd", 64'(rdo32), 64'd0);
    chk("reset wr_en", 64'(wro32), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run(0, ADD,   5, 7, 0, 0, 2'b00, 5'd3, 64'd12, 1, "add 5+7");
    run(0, MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, 2'b00, 5'd4, 64'hFFFFFFFE, 33, "mulhu ff");
    run(0, MUL,   64'hFFFFFFFF, 64'hFFFFFFFF, 0, 0, 2'b00, 5'd5, 64'h1, 33, "mul ff");
    run(0, DIVU,  100, 0, 0, 0, 2'b00, 5'd6, 64'hFFFFFFFF, 33, "divu by0");
    run(0, REMU,  100, 0, 0, 0, 2'b00, 5'd7, 64'd100, 33, "remu by0");
    run(0, DIVU,  100, 7, 0, 0, 2'b00, 5'd8, 64'd14, 33, "divu 100/7");
    run(0, REMU,  100, 7, 0, 0, 2'b00, 5'd10, 64'd2, 33, "remu 100/7");
    run(0, 3'b111, 64'h80000000, 64'h80000001, 0, 0, 2'b00, 5'd11, 64'd1, 1, "op7 as add wrap");

    run(0, ADD, 1, 1, 9, 9, 2'b01, 5'd12, 64'd10, 1, "fwd wb add");
    run(0, ADD, 1, 5, 0, 0, 2'b10, 5'd13, 64'd15, 1, "fwd ex add");
    run(0, MUL, 1, 5, 3, 100, 2'b01, 5'd14, 64'd15, 33, "fwd wb mul");

    flush_run(10, "flush busy10");
    run(0, ADD, 2, 3, 0, 0, 2'b00, 5'd15, 64'd5, 1, "add after flush");
    flush_run(32, "flush last");
    run(0, ADD, 4, 4, 0, 0, 2'b00, 5'd16, 64'd8, 1, "add after flush2");

    run(1, MUL, 64'hFF, 64'hFF, 0, 0, 2'b00, 5'd17, 64'h01, 9, "x8 mul ff");

    @(negedge Clk);
    op = DIVU; fa = 2'b00; rd = 5'd18; wr = 1'b1;
    v32 = 1'b1; rs1_32 = 32'd1000; rs2_32 = 32'd3;
    for (int n = 0; n < 5; n++) begin
      @(negedge Clk);
      v32 = 1'b0;
    end
    Reset = 1'b1;
    #1;
    chk("rst mid valid", 64'(ev32), 64'd0);
    chk("rst mid stall", 64'(st32), 64'd0);
    chk("rst mid result", 64'(res32), 64'd0);
    chk("rst mid rd", 64'(rdo32), 64'd0);
    chk("rst mid wr_en", 64'(wro32), 64'd0);
    chk("rst x8 result", 64'(res8), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run(0, DIVU,  100, 7, 0, 0, 2'b00, 5'd19, 64'd14, 33, "divu after rst");
    run(1, MULHU, 64'hFF, 64'hFF, 0, 0, 2'b00, 5'd20, 64'hFE, 9, "x8 mulhu ff");
    run(1, MUL,   64'hFF, 64'hFF, 0, 0, 2'b00, 5'd21, 64'h01, 9, "x8 mul after rst");
    run(1, REMU,  100, 7, 0, 0, 2'b00, 5'd22, 64'd2, 9, "x8 remu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
